branch_fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for branch/JALR operands resolved in ID. It replaces per-stage rd/we wiring with an internal scoreboard of in-flight writers, shifted in step with the pipeline. For each consumer source it returns the youngest ready producer stage, or a stall when that producer's data is not yet available (load-use). It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/riscv_pipe_pkg.sv | 14 +
 rtl/branch_fwd_src_sel.sv | 39 +++
 rtl/branch_fwd_scoreboard.sv | 88 ++++++++
 tb/tb_branch_fwd_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the ID-stage forwarding logic: register address
// width, the in-flight writer slot record and the register-file select code.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } slot_t;

endpackage

// File: rtl/branch_fwd_src_sel.sv
// Per-source forwarding select: the youngest matching in-flight writer wins,
// and if its data is not yet available the source requests a stall instead.
module branch_fwd_src_sel
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int READY_ALU  = 1,
  parameter int READY_LOAD = 2,
  parameter int SEL_W      = 2
) (
  input  slot_t [DEPTH-1:0]       slots,
  input  logic                    req,
  input  logic [REG_ADDR_W-1:0]   addr,
  output logic [SEL_W-1:0]        sel,
  output logic                    stall
);

  logic found;

  always_comb begin
    sel   = SEL_W'(FWD_RF);
    stall = 1'b0;
    found = 1'b0;
    // x0 is hardwired, so it can never depend on an in-flight writer
    if (req && (addr != '0)) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (!found && slots[s].valid && (slots[s].rd == addr)) begin
          found = 1'b1;
          if (s >= (slots[s].is_load ? READY_LOAD : READY_ALU)) begin
            sel = SEL_W'(s + 1);
          end else begin
            stall = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/branch_fwd_scoreboard.sv
// Scoreboard of in-flight register writers shifted with the pipeline, driving
// branch/JALR operand forwarding selects, load-use stalls and a stall counter.
module branch_fwd_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
  parameter int READY_ALU  = 1,
  parameter int READY_LOAD = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          advance,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic                          issue_we,
  input  logic                          issue_is_load,
  input  logic                          src_req,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          hazard_stall,
  output logic [CNT_W-1:0]              stall_cnt
);

  slot_t [DEPTH-1:0] slots_q, slots_d;
  slot_t             issue_slot;
  logic [NUM_SRC-1:0] src_stall;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    branch_fwd_src_sel #(
      .DEPTH      (DEPTH),
      .READY_ALU  (READY_ALU),
      .READY_LOAD (READY_LOAD),
      .SEL_W      (SEL_W)
    ) u_sel (
      .slots (slots_q),
      .req   (src_req & src_valid[i]),
      .addr  (src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .sel   (fwd_sel[i*SEL_W +: SEL_W]),
      .stall (src_stall[i])
    );
  end

  assign hazard_stall = |src_stall;
  assign stall_cnt    = cnt_q;

  always_comb begin
    // a stalled ID stage sends a bubble into EX whatever it is holding
    issue_slot         = '0;
    issue_slot.valid   = issue_valid & issue_we & (issue_rd != '0) & ~hazard_stall;
    issue_slot.rd      = issue_rd;
    issue_slot.is_load = issue_is_load;

    slots_d = slots_q;
    if (flush) begin
      slots_d = '0;
    end else if (advance) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        slots_d[i] = slots_q[i-1];
      end
      slots_d[0] = issue_slot;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// Bench for branch_fwd_scoreboard: directed vector table, multi-cycle corner
// sequences, then random traffic against an in-order instruction-queue model.
module tb_branch_fwd_scoreboard;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           advance, flush, issue_valid, issue_we, issue_is_load, src_req;
  logic [AW-1:0]  issue_rd;
  logic [1:0]     src_valid;
  logic [2*AW-1:0] src_addr;
  logic [3:0]     fwd_sel;
  logic           hazard_stall;
  logic [CW-1:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_fwd_scoreboard #(
    .NUM_SRC (2), .DEPTH (3), .REG_ADDR_W (AW),
    .READY_ALU (1), .READY_LOAD (2), .CNT_W (CW)
  ) dut (
    .clk (clk), .rst (rst), .advance (advance), .flush (flush),
    .issue_valid (issue_valid), .issue_rd (issue_rd), .issue_we (issue_we),
    .issue_is_load (issue_is_load), .src_req (src_req), .src_valid (src_valid),
    .src_addr (src_addr), .fwd_sel (fwd_sel), .hazard_stall (hazard_stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fl; bit ad; bit iv; int rd; bit we; bit ld;
    bit req; bit [1:0] sv; int a0; int a1;
    int e0; int e1; bit est; int ecnt;
  } vec_t;

  typedef struct { bit v; int rd; bit ld; } rec_t;

  vec_t tbl[20];
  rec_t pipe[$];

  function automatic vec_t mk(bit fl, bit ad, bit iv, int rd, bit we, bit ld,
                              bit req, bit [1:0] sv, int a0, int a1,
                              int e0, int e1, bit est, int ecnt);
    vec_t v;
    v.fl = fl; v.ad = ad; v.iv = iv; v.rd = rd; v.we = we; v.ld = ld;
    v.req = req; v.sv = sv; v.a0 = a0; v.a1 = a1;
    v.e0 = e0; v.e1 = e1; v.est = est; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic drive(bit fl, bit ad, bit iv, int rd, bit we, bit ld,
                       bit req, bit [1:0] sv, int a0, int a1);
    flush = fl; advance = ad; issue_valid = iv; issue_rd = AW'(rd);
    issue_we = we; issue_is_load = ld; src_req = req; src_valid = sv;
    src_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: pipe[k] is the instruction k stages past ID (0 = EX).
  function automatic int m_sel(int a, output bit st);
    st = 1'b0;
    if (a == 0) return 0;
    foreach (pipe[k]) begin
      if (pipe[k].v && pipe[k].rd == a) begin
        if (k >= (pipe[k].ld ? 2 : 1)) return k + 1;
        st = 1'b1;
        return 0;
      end
    end
    return 0;
  endfunction

  function automatic void m_clear();
    rec_t e;
    e.v = 1'b0; e.rd = 0; e.ld = 1'b0;
    pipe.delete();
    for (int k = 0; k < 3; k++) pipe.push_back(e);
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

    //          fl ad iv rd we ld req sv     a0 a1  e0 e1 st cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1, 2'b11,  5, 6,  0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 5, 1, 0, 0, 2'b00,  0, 0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 2'b01,  5, 0,  0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 2'b00,  0, 0,  0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 2'b11,  5, 6,  2, 0, 0, 1);
    tbl[5]  = mk(0, 1, 1, 7, 1, 1, 0, 2'b00,  0, 0,  0, 0, 0, 1);
    tbl[6]  = mk(0, 1, 1, 8, 1, 0, 1, 2'b01,  7, 0,  0, 0, 1, 1);
    tbl[7]  = mk(0, 1, 1, 8, 1, 0, 1, 2'b01,  7, 0,  0, 0, 1, 2);
    tbl[8]  = mk(0, 1, 1, 8, 1, 0, 1, 2'b01,  7, 0,  3, 0, 0, 3);
    tbl[9]  = mk(0, 1, 1, 9, 1, 0, 0, 2'b00,  0, 0,  0, 0, 0, 3);
    tbl[10] = mk(0, 1, 1, 0, 1, 0, 0, 2'b00,  0, 0,  0, 0, 0, 3);
    tbl[11] = mk(0, 1, 1, 9, 1, 1, 1, 2'b11,  0, 8,  0, 3, 0, 3);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 2'b11,  9, 9,  0, 0, 1, 3);
    tbl[13] = mk(1, 1, 1, 10, 1, 0, 1, 2'b11, 9, 9,  0, 0, 1, 4);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 2'b11,  9, 9,  0, 0, 0, 5);
    tbl[15] = mk(0, 1, 1, 11, 1, 0, 0, 2'b00, 0, 0,  0, 0, 0, 5);
    tbl[16] = mk(0, 1, 1, 12, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 5);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 2'b11, 12, 11, 0, 2, 0, 5);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 12, 11, 0, 0, 0, 5);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 12, 11, 0, 0, 0, 5);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].fl, tbl[r].ad, tbl[r].iv, tbl[r].rd, tbl[r].we, tbl[r].ld,
            tbl[r].req, tbl[r].sv, tbl[r].a0, tbl[r].a1);
      @(negedge clk);
      chk($sformatf("row%0d sel0", r), int'(fwd_sel[1:0]), tbl[r].e0);
      chk($sformatf("row%0d sel1", r), int'(fwd_sel[3:2]), tbl[r].e1);
      chk($sformatf("row%0d stall", r), int'(hazard_stall), int'(tbl[r].est));
      chk($sformatf("row%0d cnt", r), int'(stall_cnt), tbl[r].ecnt);
      @(posedge clk);
      #1;
    end

    // Persistent load-use stall without advance: counter climbs then saturates
    drive(0, 1, 1, 12, 1, 1, 0, 2'b00, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 1, 2'b01, 12, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 4) chk("cnt_climb", int'(stall_cnt), 9);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("hold_stall", int'(hazard_stall), 1);
    chk("cnt_saturate", int'(stall_cnt), CMAX);

    // Asynchronous reset in the middle of the cycle
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", int'(stall_cnt), 0);
    chk("async_rst_stall", int'(hazard_stall), 0);
    chk("async_rst_sel0", int'(fwd_sel[1:0]), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic against the queue model
    m_clear();
    begin
      int m_cnt;
      m_cnt = 0;
      for (int n = 0; n < 1500; n++) begin
        bit fl, ad, iv, we, ld, req, st0, st1, est;
        bit [1:0] sv;
        int rd, a0, a1, e0, e1;
        rec_t nw;
        fl  = ($urandom_range(0, 15) == 0);
        ad  = ($urandom_range(0, 3) != 0);
        iv  = ($urandom_range(0, 7) != 0);
        we  = ($urandom_range(0, 7) != 0);
        ld  = ($urandom_range(0, 2) == 0);
        req = ($urandom_range(0, 3) != 0);
        sv  = 2'($urandom_range(0, 3));
        rd  = $urandom_range(0, 7);
        a0  = $urandom_range(0, 7);
        a1  = $urandom_range(0, 7);
        drive(fl, ad, iv, rd, we, ld, req, sv, a0, a1);
        @(negedge clk);
        st0 = 1'b0; st1 = 1'b0; e0 = 0; e1 = 0;
        if (req && sv[0]) e0 = m_sel(a0, st0);
        if (req && sv[1]) e1 = m_sel(a1, st1);
        est = st0 | st1;
        chk($sformatf("rnd%0d sel0", n), int'(fwd_sel[1:0]), e0);
        chk($sformatf("rnd%0d sel1", n), int'(fwd_sel[3:2]), e1);
        chk($sformatf("rnd%0d stall", n), int'(hazard_stall), int'(est));
        chk($sformatf("rnd%0d cnt", n), int'(stall_cnt), m_cnt);
        if (fl) begin
          m_clear();
        end else if (ad) begin
          nw.v  = iv && we && (rd != 0) && !est;
          nw.rd = rd;
          nw.ld = ld;
          pipe.push_front(nw);
          void'(pipe.pop_back());
        end
        if (est && m_cnt < CMAX) m_cnt++;
        @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
